// File: rtl/engine_result_queue.sv
// ---------------------------------------------------------------------------
// engine_result_queue
//
// Buffers per-pixel results from a fractal engine. Each result is coloured
// when it is written, stored with its frame markers, and presented to a
// valid/ready pixel stream. Raster order is checked as pixels leave the
// queue, and any violation sets a sticky error flag.
//
// Storage is a circular buffer plus a registered output stage. The total
// occupancy (buffered entries plus a valid output register) never exceeds
// DEPTH. An empty queue forwards a new write straight into the output
// register, so the entry is valid one cycle after it is written.
//
// Ports
//   clk            single clock, rising edge
//   reset          asynchronous active-low reset
//   in_valid       engine result strobe
//   iterations     escape iteration count
//   xpixel/ypixel  pixel column / row of the result
//   iterations_max in-set threshold, static during a frame
//   out_ready      downstream accept
//   full_queue     back-pressure to the engine (occupancy == DEPTH)
//   out_valid      output data valid
//   out_data       RGB {R[23:16], G[15:8], B[7:0]}
//   out_sof        first pixel of frame
//   out_eol        last pixel of line
//   order_err      sticky raster-order violation
// ---------------------------------------------------------------------------
module engine_result_queue #(
    parameter int PIXEL_DATA_WIDTH = 10,
    parameter int ITERATIONS_WIDTH = 6,
    parameter int DEPTH            = 8,
    parameter int X_SIZE           = 640,
    parameter int Y_SIZE           = 480
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    input  logic [ITERATIONS_WIDTH-1:0] iterations,
    input  logic [PIXEL_DATA_WIDTH-1:0] xpixel,
    input  logic [PIXEL_DATA_WIDTH-1:0] ypixel,
    input  logic [ITERATIONS_WIDTH-1:0] iterations_max,
    input  logic                        out_ready,
    output logic                        full_queue,
    output logic                        out_valid,
    output logic [23:0]                 out_data,
    output logic                        out_sof,
    output logic                        out_eol,
    output logic                        order_err
);

    localparam int PW = PIXEL_DATA_WIDTH;
    localparam int AW = $clog2(DEPTH);
    localparam int EW = 26 + 2 * PW;
    localparam logic [AW:0]   DEPTH_CNT = (AW + 1)'(DEPTH);
    localparam logic [PW-1:0] X_LAST    = PW'(X_SIZE - 1);
    localparam logic [PW-1:0] Y_LAST    = PW'(Y_SIZE - 1);

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   occupancy;
    logic [AW:0]   fifo_cnt;

    logic [PW-1:0] out_x;
    logic [PW-1:0] out_y;
    logic [PW-1:0] ex;
    logic [PW-1:0] ey;

    logic [7:0]    level;
    logic [23:0]   colour;
    logic          in_sof;
    logic          in_eol;
    logic [EW-1:0] in_entry;
    logic [EW-1:0] head;

    logic push;
    logic pop;
    logic load_out;
    logic fifo_nonempty;
    logic bypass;
    logic mem_write;

    always_comb begin
        // Iteration count left-aligned into 8 bits, LSBs zero-filled.
        level    = 8'(iterations) << (8 - ITERATIONS_WIDTH);
        colour   = (iterations == iterations_max) ? 24'h000000 : {level, ~level, 8'hFF};
        in_sof   = (xpixel == '0) && (ypixel == '0);
        in_eol   = (xpixel == X_LAST);
        in_entry = {colour, in_sof, in_eol, xpixel, ypixel};
        head     = mem[rd_ptr];

        full_queue    = (occupancy == DEPTH_CNT);
        push          = in_valid && !full_queue;
        pop           = out_valid && out_ready;
        // Output register can take a new entry when empty or being drained.
        load_out      = !out_valid || out_ready;
        fifo_nonempty = (fifo_cnt != '0);
        // Empty buffer: a new write goes straight to the output register.
        bypass        = load_out && !fifo_nonempty && push;
        mem_write     = push && !bypass;
    end

    always_ff @(posedge clk) begin
        if (mem_write) begin
            mem[wr_ptr] <= in_entry;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
            fifo_cnt  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sof   <= 1'b0;
            out_eol   <= 1'b0;
            out_x     <= '0;
            out_y     <= '0;
            ex        <= '0;
            ey        <= '0;
            order_err <= 1'b0;
        end else begin
            occupancy <= occupancy + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

            if (mem_write) begin
                wr_ptr <= wr_ptr + AW'(1);
            end

            case ({mem_write, load_out && fifo_nonempty})
                2'b10:   fifo_cnt <= fifo_cnt + (AW + 1)'(1);
                2'b01:   fifo_cnt <= fifo_cnt - (AW + 1)'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase

            if (load_out) begin
                if (fifo_nonempty) begin
                    {out_data, out_sof, out_eol, out_x, out_y} <= head;
                    out_valid <= 1'b1;
                    rd_ptr    <= rd_ptr + AW'(1);
                end else if (push) begin
                    {out_data, out_sof, out_eol, out_x, out_y} <= in_entry;
                    out_valid <= 1'b1;
                end else begin
                    out_valid <= 1'b0;
                end
            end

            // Raster checking on the departing pixel. A start-of-frame pixel
            // resynchronises the expected position to the pixel after it.
            if (pop) begin
                if (out_sof) begin
                    ex <= PW'(1);
                    ey <= '0;
                end else begin
                    if ((out_x != ex) || (out_y != ey)) begin
                        order_err <= 1'b1;
                    end
                    if (ex == X_LAST) begin
                        ex <= '0;
                        ey <= (ey == Y_LAST) ? '0 : ey + PW'(1);
                    end else begin
                        ex <= ex + PW'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_engine_result_queue.sv
module tb_engine_result_queue;

    localparam int PW     = 10;
    localparam int IW     = 6;
    localparam int DEPTH  = 8;
    localparam int X_SIZE = 640;
    localparam int Y_SIZE = 480;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic [IW-1:0] iterations;
    logic [PW-1:0] xpixel;
    logic [PW-1:0] ypixel;
    logic [IW-1:0] iterations_max;
    logic          out_ready;
    logic          full_queue;
    logic          out_valid;
    logic [23:0]   out_data;
    logic          out_sof;
    logic          out_eol;
    logic          order_err;

    engine_result_queue #(
        .PIXEL_DATA_WIDTH(PW),
        .ITERATIONS_WIDTH(IW),
        .DEPTH(DEPTH),
        .X_SIZE(X_SIZE),
        .Y_SIZE(Y_SIZE)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .iterations(iterations),
        .xpixel(xpixel),
        .ypixel(ypixel),
        .iterations_max(iterations_max),
        .out_ready(out_ready),
        .full_queue(full_queue),
        .out_valid(out_valid),
        .out_data(out_data),
        .out_sof(out_sof),
        .out_eol(out_eol),
        .order_err(order_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] data;
        bit          sof;
        bit          eol;
        int          x;
        int          y;
    } entry_t;

    typedef struct {
        bit          iv;
        int          it;
        int          x;
        int          y;
        bit          rdy;
        bit          e_ov;
        logic [23:0] e_data;
        bit          e_sof;
        bit          e_eol;
    } vec_t;

    int     checks;
    int     errors;
    entry_t q[$];
    int     m_ex;
    int     m_ey;
    bit     m_err;

    function automatic logic [23:0] colour(input int it, input int mx);
        int l;
        if (it == mx) return 24'h000000;
        l = it * (256 / (1 << IW));
        return 24'((l << 16) + ((255 - l) << 8) + 255);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        check("out_valid", 32'(out_valid), 32'(q.size() > 0));
        check("full_queue", 32'(full_queue), 32'(q.size() == DEPTH));
        check("order_err", 32'(order_err), 32'(m_err));
        if (q.size() > 0) begin
            check("out_data", 32'(out_data), 32'(q[0].data));
            check("out_sof", 32'(out_sof), 32'(q[0].sof));
            check("out_eol", 32'(out_eol), 32'(q[0].eol));
        end
    endtask

    task automatic tick();
        bit     do_pop;
        bit     do_push;
        entry_t e;
        entry_t p;
        do_pop  = (q.size() > 0) && out_ready;
        do_push = in_valid && (q.size() < DEPTH);
        e.x     = int'(xpixel);
        e.y     = int'(ypixel);
        e.data  = colour(int'(iterations), int'(iterations_max));
        e.sof   = (e.x == 0) && (e.y == 0);
        e.eol   = (e.x == X_SIZE - 1);
        @(posedge clk);
        #1;
        if (do_pop) begin
            p = q.pop_front();
            if (p.sof) begin
                m_ex = 1;
                m_ey = 0;
            end else begin
                if (p.x != m_ex || p.y != m_ey) m_err = 1'b1;
                m_ex = m_ex + 1;
                if (m_ex == X_SIZE) begin
                    m_ex = 0;
                    m_ey = (m_ey + 1) % Y_SIZE;
                end
            end
        end
        if (do_push) q.push_back(e);
        compare_model();
    endtask

    task automatic apply_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        reset     = 1'b0;
        #3;
        q.delete();
        m_ex  = 0;
        m_ey  = 0;
        m_err = 1'b0;
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_full", 32'(full_queue), 32'(0));
        check("rst_order_err", 32'(order_err), 32'(0));
        check("rst_out_data", 32'(out_data), 32'(0));
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic write_px(input int it, input int x, input int y);
        in_valid   = 1'b1;
        iterations = IW'(it);
        xpixel     = PW'(x);
        ypixel     = PW'(y);
    endtask

    vec_t vt[6];

    initial begin
        int gx;
        int gy;
        bit acc;

        checks = 0;
        errors = 0;
        reset  = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        iterations = '0;
        xpixel = '0;
        ypixel = '0;
        iterations_max = 6'd63;

        vt[0] = '{1'b1,  3,   0, 0, 1'b1, 1'b1, 24'h0CF3FF, 1'b1, 1'b0};
        vt[1] = '{1'b1, 63,   1, 0, 1'b1, 1'b1, 24'h000000, 1'b0, 1'b0};
        vt[2] = '{1'b1,  1, 639, 0, 1'b1, 1'b1, 24'h04FBFF, 1'b0, 1'b1};
        vt[3] = '{1'b1, 32,   0, 1, 1'b1, 1'b1, 24'h807FFF, 1'b0, 1'b0};
        vt[4] = '{1'b0,  0,   0, 0, 1'b1, 1'b0, 24'h000000, 1'b0, 1'b0};
        vt[5] = '{1'b1,  0,   5, 5, 1'b0, 1'b1, 24'h00FFFF, 1'b0, 1'b0};

        #12;
        apply_reset();

        // Table-driven vectors: colour, markers and one-cycle latency.
        for (int i = 0; i < 6; i++) begin
            in_valid   = vt[i].iv;
            iterations = IW'(vt[i].it);
            xpixel     = PW'(vt[i].x);
            ypixel     = PW'(vt[i].y);
            out_ready  = vt[i].rdy;
            tick();
            check($sformatf("tbl%0d_ov", i), 32'(out_valid), 32'(vt[i].e_ov));
            if (vt[i].e_ov) begin
                check($sformatf("tbl%0d_data", i), 32'(out_data), 32'(vt[i].e_data));
                check($sformatf("tbl%0d_sof", i), 32'(out_sof), 32'(vt[i].e_sof));
                check($sformatf("tbl%0d_eol", i), 32'(out_eol), 32'(vt[i].e_eol));
            end
        end

        // Fill to DEPTH with the sink stalled; the ninth write is dropped.
        apply_reset();
        for (int k = 1; k <= 9; k++) begin
            write_px(k, k, 0);
            tick();
            if (k == 7) check("fill_not_full", 32'(full_queue), 32'(0));
            if (k == 8) check("fill_full", 32'(full_queue), 32'(1));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            check($sformatf("drain%0d_data", k), 32'(out_data), 32'(colour(k, 63)));
            tick();
        end
        check("drain_empty", 32'(out_valid), 32'(0));

        // Full queue with simultaneous write and accept: pop only.
        apply_reset();
        for (int k = 10; k < 18; k++) begin
            write_px(k, k, 0);
            tick();
        end
        check("full_before", 32'(full_queue), 32'(1));
        write_px(50, 30, 0);
        out_ready = 1'b1;
        tick();
        check("full_after_pop", 32'(full_queue), 32'(0));
        check("full_next_head", 32'(out_data), 32'(colour(11, 63)));
        in_valid = 1'b0;
        for (int k = 0; k < 9; k++) tick();
        check("full_drained", 32'(out_valid), 32'(0));

        // Raster order: (0,0) then (2,0) is an error that stays set.
        apply_reset();
        out_ready = 1'b1;
        write_px(5, 0, 0);
        tick();
        write_px(5, 2, 0);
        tick();
        check("order_ok_after_sof", 32'(order_err), 32'(0));
        write_px(5, 3, 0);
        tick();
        check("order_err_set", 32'(order_err), 32'(1));
        write_px(5, 4, 0);
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        check("order_err_sticky", 32'(order_err), 32'(1));

        // Reset with entries queued: outputs clear at once, nothing stale.
        apply_reset();
        for (int k = 1; k <= 5; k++) begin
            write_px(k + 20, k, 0);
            tick();
        end
        check("pre_rst_valid", 32'(out_valid), 32'(1));
        apply_reset();
        write_px(9, 0, 0);
        tick();
        check("post_rst_first", 32'(out_data), 32'(colour(9, 63)));
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("post_rst_no_stale", 32'(out_valid), 32'(0));

        // Randomised traffic against the queue model.
        apply_reset();
        iterations_max = 6'd20;
        gx = 0;
        gy = 0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 39) == 0) begin
                case ($urandom_range(0, 2))
                    0: begin gx = 0; gy = 0; end
                    1: gx = X_SIZE - 1;
                    default: begin
                        gx = int'($urandom_range(0, X_SIZE - 1));
                        gy = int'($urandom_range(0, Y_SIZE - 1));
                    end
                endcase
            end
            in_valid   = ($urandom_range(0, 9) < 6);
            out_ready  = ($urandom_range(0, 9) < 7);
            iterations = IW'($urandom_range(0, 63));
            if ($urandom_range(0, 7) == 0) iterations = 6'd20;
            xpixel = PW'(gx);
            ypixel = PW'(gy);
            acc = in_valid && (q.size() < DEPTH);
            tick();
            if (acc) begin
                gx = gx + 1;
                if (gx == X_SIZE) begin
                    gx = 0;
                    gy = (gy + 1) % Y_SIZE;
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
